negate_arbiter: RTL and testbench
=================================

NEGATE_ARBITER -- requirements
Module: negate_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req0_valid  input  1  requester 0 has an operand.
REQ-005 Port: req0_data  input  WIDTH  requester 0 operand.
REQ-006 Port: req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-007 Port: req1_valid  input  1  requester 1 has an operand.
REQ-008 Port: req1_data  input  WIDTH  requester 1 operand.
REQ-009 Port: req1_ready  output  1  requester 1 operand accepted this cycle.
REQ-010 Port: res_valid  output  1  result register holds a result.
REQ-011 Port: res_data  output  WIDTH  two's complement (negation) of accepted operand.
REQ-012 Port: res_id  output  1  index of requester owning res_data.
REQ-013 Port: res_ovf  output  1  operand was most-negative value (1 followed by zeros).
REQ-014 Port: res_ready  input  1  consumer takes result this cycle.

Function
REQ-015 Block SHALL share one combinational negation unit between two requesters via round-robin arbitration, one registered result stage.
REQ-016 Transfer on request side SHALL occur when reqN_valid && reqN_ready; on result side when res_valid && res_ready.
REQ-017 FSM SHALL have states EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-018 Slot free SHALL be defined as (state==EMPTY) || res_ready; accept is permitted only when slot free.
REQ-019 When slot free and exactly one reqN_valid, reqN_ready SHALL be 1 that cycle (combinational), other ready 0.
REQ-020 When slot free and both valid, grant SHALL go to requester not granted last; last_grant resets to 1 so requester 0 wins first contention.
REQ-021 last_grant SHALL update only on an accepted transfer.
REQ-022 On accept, next cycle: res_data = (~data + 1) mod 2^WIDTH, res_id = granted index, res_ovf = (data == 1 followed by WIDTH-1 zeros), state FULL; latency exactly 1 cycle.
REQ-023 Zero operand SHALL yield res_data 0, res_ovf 0.
REQ-024 FULL with res_ready=0: res_* SHALL hold stable, both reqN_ready SHALL be 0.
REQ-025 FULL with res_ready=1 and a valid request: new result SHALL load next cycle (back-to-back, no bubble), state stays FULL.
REQ-026 FULL with res_ready=1 and no request: state SHALL go EMPTY.
REQ-027 reqN_ready SHALL never be 1 while reqN_valid is 0.
REQ-028 Throughput SHALL be one result per cycle under continuous res_ready=1.

Reset
REQ-029 rst_n low SHALL asynchronously force state EMPTY, res_valid 0, res_data 0, res_id 0, res_ovf 0, last_grant 1.
REQ-030 reqN_ready SHALL be 0 while rst_n is low.
REQ-031 Reset mid-operation SHALL discard any held result without emitting it; first accept after release follows REQ-020 from reset value.

Structure
REQ-032 Shared package SHALL hold WIDTH default, state encoding (EMPTY, FULL), requester index constants.
REQ-033 Negation SHALL be a separate combinational sub-module twos_comp_unit (data in; negated data and ovf out), instantiated once.
REQ-034 Arbiter, FSM and result register SHALL reside in negate_arbiter; target 120-250 RTL lines.

Verification
REQ-035 Reset: assert rst_n=0 mid-FULL -> res_valid, res_data, res_id, res_ovf all 0 immediately, readies 0.
REQ-036 Single: req0 0011, res_ready=1 -> req0_ready=1 same cycle; next cycle res_data 1101, res_id 0, res_ovf 0.
REQ-037 Contention: both valid (req0 0001, req1 0010) held, res_ready=1 -> results 1111 id0, then 1110 id1, alternating thereafter.
REQ-038 Boundary: operand 1000 -> res_data 1000, res_ovf 1; operand 0000 -> res_data 0000, res_ovf 0; exhaustive 0000..1111 matches (16-x) mod 16.
REQ-039 Backpressure: FULL with result 0110, res_ready=0 for 3 cycles, req1 valid -> res_data stays 0110, req1_ready 0; res_ready=1 -> req1 accepted same cycle.
REQ-040 Back-to-back: continuous req0 valid, res_ready=1 -> res_valid constant 1, new result every cycle.

Source files
------------

// File: rtl/negate_arbiter_pkg.sv
// negate_arbiter_pkg: shared width default, FSM encoding and requester indices.
package negate_arbiter_pkg;
    localparam int WIDTH_DEF = 4;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/negate_arbiter_twos_comp_unit.sv
// twos_comp_unit: combinational two's complement negation with most-negative flag.
module twos_comp_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_neg,
    output logic             o_ovf
);
    assign o_neg = ~i_data + WIDTH'(1);
    assign o_ovf = i_data == {1'b1, {(WIDTH-1){1'b0}}};
endmodule

// File: rtl/negate_arbiter.sv
// negate_arbiter: two requesters share one negation unit via round-robin,
// with a single registered result stage.
module negate_arbiter
    import negate_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_ovf,
    input  logic             res_ready
);
    state_t           r_state, w_next;
    logic             r_last_grant, r_id, r_ovf;
    logic [WIDTH-1:0] r_data, w_sel, w_neg;
    logic             w_free, w_gnt1, w_acc, w_ovf;

    twos_comp_unit #(.WIDTH(WIDTH)) u_neg (
        .i_data(w_sel),
        .o_neg (w_neg),
        .o_ovf (w_ovf)
    );

    // Requester 1 wins contention only when requester 0 was granted last.
    always_comb begin
        w_free     = rst_n && (r_state == EMPTY || res_ready);
        w_gnt1     = req1_valid && (!req0_valid || r_last_grant == REQ0);
        req0_ready = w_free && req0_valid && !w_gnt1;
        req1_ready = w_free && w_gnt1;
        w_acc      = req0_ready || req1_ready;
        w_sel      = w_gnt1 ? req1_data : req0_data;
        w_next     = w_acc ? FULL : (res_ready ? EMPTY : r_state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_last_grant <= REQ1;
            r_data       <= '0;
            r_id         <= REQ0;
            r_ovf        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_last_grant <= w_gnt1;
                r_data       <= w_neg;
                r_id         <= w_gnt1;
                r_ovf        <= w_ovf;
            end
        end
    end

    assign res_valid = r_state == FULL;
    assign res_data  = r_data;
    assign res_id    = r_id;
    assign res_ovf   = r_ovf;
endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter: directed and random checks against a transaction-level model.
module tb_negate_arbiter;
    logic       clk = 0, rst_n = 0;
    logic       req0_valid = 0, req1_valid = 0, res_ready = 0;
    logic [3:0] req0_data = 0, req1_data = 0;
    logic       req0_ready, req1_ready, res_valid, res_id, res_ovf;
    logic [3:0] res_data;
    int         n_chk = 0, n_fail = 0;
    int         m_valid, m_data, m_id, m_ovf, m_last;

    negate_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ovf(res_ovf), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic mreset();
        m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_last = 1;
    endtask

    // Which requester the rules say wins this cycle, -1 for none.
    function automatic int gnt();
        if (!rst_n || !(m_valid == 0 || res_ready)) return -1;
        if (req0_valid && req1_valid) return m_last == 1 ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic cyc();
        int g, x;
        #1;
        g = gnt();
        chk("rdy0", req0_ready, g == 0);
        chk("rdy1", req1_ready, g == 1);
        x = (g == 1) ? int'(req1_data) : int'(req0_data);
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1; m_data = (16 - x) % 16; m_id = g; m_ovf = (x == 8); m_last = g;
        end else if (res_ready) m_valid = 0;
        #1;
        chk("vld", res_valid, m_valid);
        if (m_valid) begin
            chk("data", res_data, m_data);
            chk("id", res_id, m_id);
            chk("ovf", res_ovf, m_ovf);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_vld", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_id", res_id, 0);
        chk("rst_ovf", res_ovf, 0);
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;
        mreset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mreset();
        do_reset();
        // single request, same-cycle ready and 1-cycle latency
        req0_valid = 1; req0_data = 4'b0011; res_ready = 1;
        #1 chk("single_rdy", req0_ready, 1);
        cyc();
        chk("single_data", res_data, 13);
        chk("single_id", res_id, 0);
        chk("single_ovf", res_ovf, 0);
        // contention alternates starting with requester 0
        do_reset();
        req0_valid = 1; req0_data = 4'b0001; req1_valid = 1; req1_data = 4'b0010; res_ready = 1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("cont_data", res_data, (k % 2) ? 14 : 15);
            chk("cont_id", res_id, k % 2);
        end
        // exhaustive operands back-to-back
        req1_valid = 0;
        for (int x = 0; x < 16; x++) begin
            req0_data = 4'(x);
            cyc();
            chk("neg", res_data, (16 - x) % 16);
            chk("neg_ovf", res_ovf, x == 8);
            chk("b2b_vld", res_valid, 1);
        end
        // backpressure holds result and blocks requester
        req0_valid = 0; req1_valid = 1; req1_data = 4'b1010;
        cyc();
        res_ready = 0;
        repeat (3) begin
            cyc();
            chk("bp_data", res_data, 6);
            chk("bp_rdy1", req1_ready, 0);
        end
        res_ready = 1;
        #1 chk("bp_go", req1_ready, 1);
        cyc();
        // reset while FULL discards result; first contention goes to requester 0
        #2;
        do_reset();
        req0_valid = 1; req0_data = 4'd5; req1_valid = 1; req1_data = 4'd7; res_ready = 1;
        cyc();
        chk("post_rst_id", res_id, 0);
        chk("post_rst_data", res_data, 11);
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_data  = 4'($urandom);
            req1_data  = 4'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
